// File: rtl/alfsr_sequencer.sv
// alfsr_sequencer: pulses the LFSR configurator clock, releases the ALFSR, then packs rng_in into bytes.
// Optional build macro ALFSR_SEQ_VONNEUMANN_EN enables von Neumann debiasing of sample pairs.
module alfsr_sequencer #(
    parameter int DIV    = 2,
    parameter int SETTLE = 8,
    parameter int SAMP   = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic [15:0] steps,
    output logic        lfsr_clk,
    output logic        alfsr_rst_n,
    input  logic        rng_in,
    output logic [7:0]  data,
    output logic        data_valid,
    input  logic        data_ready,
    output logic        busy,
    output logic        overrun
);

    localparam int DW = (DIV    > 1) ? $clog2(DIV)    : 1;
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int PW = (SAMP   > 1) ? $clog2(SAMP)   : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STEP_HI,
        ST_STEP_LO,
        ST_SETTLE,
        ST_COLLECT
    } state_t;

    state_t        r_state;
    logic [15:0]   r_steps;
    logic [DW-1:0] r_div_cnt;
    logic [SW-1:0] r_set_cnt;
    logic [PW-1:0] r_samp_cnt;
    logic [2:0]    r_bit_cnt;
    logic [6:0]    r_shreg;

    logic w_consume;
    logic w_div_last;
    logic w_set_last;
    logic w_sample;
    logic w_bit_en;
    logic w_bit;
    logic w_byte_done;
    logic w_load;
    logic [7:0] w_byte;

    assign w_consume  = data_valid & data_ready;
    assign w_div_last = (r_div_cnt == DW'(DIV - 1));
    assign w_set_last = (r_set_cnt == SW'(SETTLE - 1));
    // stop wins over a sample landing in the same cycle, so the partial byte is simply lost
    assign w_sample   = (r_state == ST_COLLECT) && (r_samp_cnt == '0) && !stop;

`ifdef ALFSR_SEQ_VONNEUMANN_EN
    logic r_pair_have;
    logic r_pair_a;

    // 10 -> 1, 01 -> 0: the emitted bit is always the first sample of an unequal pair
    assign w_bit_en = w_sample && r_pair_have && (r_pair_a != rng_in);
    assign w_bit    = r_pair_a;
`else
    assign w_bit_en = w_sample;
    assign w_bit    = rng_in;
`endif

    assign w_byte_done = w_bit_en && (r_bit_cnt == 3'd7);
    assign w_byte      = {r_shreg, w_bit};
    assign w_load      = w_byte_done && (!data_valid || w_consume);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_steps     <= '0;
            r_div_cnt   <= '0;
            r_set_cnt   <= '0;
            r_samp_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_shreg     <= '0;
            lfsr_clk    <= 1'b0;
            alfsr_rst_n <= 1'b0;
            data        <= '0;
            data_valid  <= 1'b0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
`ifdef ALFSR_SEQ_VONNEUMANN_EN
            r_pair_have <= 1'b0;
            r_pair_a    <= 1'b0;
`endif
        end else begin
            if (w_load) begin
                data       <= w_byte;
                data_valid <= 1'b1;
            end else if (w_consume) begin
                data_valid <= 1'b0;
            end

            if (stop) begin
                r_state     <= ST_IDLE;
                lfsr_clk    <= 1'b0;
                alfsr_rst_n <= 1'b0;
                busy        <= 1'b0;
                r_bit_cnt   <= '0;
                r_shreg     <= '0;
                r_div_cnt   <= '0;
                r_set_cnt   <= '0;
                r_samp_cnt  <= '0;
`ifdef ALFSR_SEQ_VONNEUMANN_EN
                r_pair_have <= 1'b0;
`endif
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        lfsr_clk    <= 1'b0;
                        alfsr_rst_n <= 1'b0;
                        if (start) begin
                            r_steps    <= steps;
                            overrun    <= 1'b0;
                            r_bit_cnt  <= '0;
                            r_shreg    <= '0;
                            data_valid <= 1'b0;
                            r_div_cnt  <= '0;
                            r_set_cnt  <= '0;
                            busy       <= 1'b1;
`ifdef ALFSR_SEQ_VONNEUMANN_EN
                            r_pair_have <= 1'b0;
`endif
                            if (steps != 16'd0) begin
                                r_state  <= ST_STEP_HI;
                                lfsr_clk <= 1'b1;
                            end else begin
                                r_state     <= ST_SETTLE;
                                alfsr_rst_n <= 1'b1;
                            end
                        end
                    end

                    ST_STEP_HI: begin
                        if (w_div_last) begin
                            r_div_cnt <= '0;
                            r_state   <= ST_STEP_LO;
                            lfsr_clk  <= 1'b0;
                        end else begin
                            r_div_cnt <= r_div_cnt + 1'b1;
                        end
                    end

                    ST_STEP_LO: begin
                        if (w_div_last) begin
                            r_div_cnt <= '0;
                            r_steps   <= r_steps - 16'd1;
                            if (r_steps != 16'd1) begin
                                r_state  <= ST_STEP_HI;
                                lfsr_clk <= 1'b1;
                            end else begin
                                r_state     <= ST_SETTLE;
                                alfsr_rst_n <= 1'b1;
                                r_set_cnt   <= '0;
                            end
                        end else begin
                            r_div_cnt <= r_div_cnt + 1'b1;
                        end
                    end

                    ST_SETTLE: begin
                        if (w_set_last) begin
                            r_set_cnt  <= '0;
                            r_samp_cnt <= '0;
                            r_state    <= ST_COLLECT;
                        end else begin
                            r_set_cnt <= r_set_cnt + 1'b1;
                        end
                    end

                    ST_COLLECT: begin
                        if (r_samp_cnt == PW'(SAMP - 1)) begin
                            r_samp_cnt <= '0;
                        end else begin
                            r_samp_cnt <= r_samp_cnt + 1'b1;
                        end
`ifdef ALFSR_SEQ_VONNEUMANN_EN
                        if (w_sample) begin
                            r_pair_have <= !r_pair_have;
                            r_pair_a    <= rng_in;
                        end
`endif
                        if (w_bit_en) begin
                            if (w_byte_done) begin
                                r_bit_cnt <= '0;
                                if (!w_load) begin
                                    overrun <= 1'b1;
                                end
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                                r_shreg   <= {r_shreg[5:0], w_bit};
                            end
                        end
                    end

                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/alfsr_sequencer.md
# alfsr_sequencer

Control sequencer for the analog-LFSR random source. It advances the LFSR configurator to a chosen state by issuing a programmed number of configurator clock pulses, then releases the ALFSR from reset and waits a settle interval. After that it collects the digitized random bit stream into bytes and hands them out over a valid/ready interface. It sits between the top-level I/O and the ALFSR instance and replaces manual driving of the configurator clock and ALFSR reset pins.

## Interface
Parameters:
- `DIV`, 2: half-period of `lfsr_clk` in `clk` cycles (≥1).
- `SETTLE`, 8: cycles from ALFSR reset release to first sample (≥1).
- `SAMP`, 1: `clk` cycles between successive samples of `rng_in` (≥1).

Ports:
- `clk` in 1: system clock, also the digitization clock.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: begin a sequence; honoured only in IDLE.
- `stop` in 1: abort to IDLE from any state.
- `steps` in 16: number of configurator pulses; latched on accepted `start`.
- `lfsr_clk` out 1: configurator clock, drives `ui_in[0]` role.
- `alfsr_rst_n` out 1: ALFSR reset, active low.
- `rng_in` in 1: digitized ALFSR output.
- `data` out 8: assembled random byte.
- `data_valid` out 1: `data` holds an unconsumed byte.
- `data_ready` in 1: consumer accepts `data` when high with `data_valid`.
- `busy` out 1: high in any state except IDLE.
- `overrun` out 1: sticky; a completed byte was dropped.

## Operation
- States: IDLE, STEP_HI, STEP_LO, SETTLE, COLLECT.
- Reset values: state IDLE, `lfsr_clk`=0, `alfsr_rst_n`=0, `data`=0, `data_valid`=0, `busy`=0, `overrun`=0, and all counters 0.
- IDLE behaviour:
  - `alfsr_rst_n`=0 and `lfsr_clk`=0.
  - On `start`, latch `steps`, clear `overrun`, the bit counter and `data_valid`.
  - Go to STEP_HI if `steps`≠0, otherwise go to SETTLE.
- STEP_HI: `lfsr_clk`=1 for `DIV` cycles, then go to STEP_LO.
- STEP_LO: `lfsr_clk`=0 for `DIV` cycles, then decrement the remaining count. Go to STEP_HI if the count is nonzero, otherwise go to SETTLE.
- SETTLE: `alfsr_rst_n`=1. Wait `SETTLE` cycles, then go to COLLECT.
- COLLECT sampling:
  - `alfsr_rst_n`=1.
  - `rng_in` is sampled on the first cycle in COLLECT and then every `SAMP` cycles.
  - Each accepted bit is shifted as `shreg={shreg[6:0],bit}`, so the first bit ends up in `data[7]`.
- COLLECT byte completion (on the 8th accepted bit):
  - If `data_valid`=0, or `data_valid`&&`data_ready` in that cycle, load `data`, set `data_valid`=1 and reset the bit counter.
  - Otherwise drop the byte, set `overrun`=1 and reset the bit counter.
- COLLECT runs until `stop`.
- `data_valid` clears on `data_valid`&&`data_ready` unless a new byte is loaded in the same cycle; in that case it stays 1 with the new `data`.
- `stop` is synchronous and has priority over `start` and all transitions:
  - Next state is IDLE, with `lfsr_clk`=0 and `alfsr_rst_n`=0.
  - The partial byte is discarded.
  - A pending `data_valid` byte is kept until consumed.
  - `overrun` is held.
- `start` while `busy` is ignored.
- `steps`=65535 must complete without wrap.

## Timing
- Accepted `start` at edge k: state changes at k+1, and `lfsr_clk` rises at edge k+1.
- Sequence length to reach SETTLE is 2·DIV·`steps` cycles; SETTLE lasts `SETTLE` cycles; the first sample falls on the first COLLECT cycle.
- All outputs are registered.
- Byte latency is 8·SAMP cycles of accepted bits; `data_valid` rises the cycle after the 8th sample edge.
- `lfsr_clk` pulses are glitch-free: registered and with a 50% duty cycle.

## Configuration
- `ALFSR_SEQ_VONNEUMANN_EN` defined:
  - Samples are consumed in pairs (a, b). 01→bit 0, 10→bit 1, 00/11→no bit.
  - A byte needs 8 emitted bits, and the pair register is cleared on `stop`/`start`.
- Undefined: every sample is one bit, with no pairing logic.

## Test plan
- Reset mid-STEP_HI (`rst_n` low asynchronously) → all outputs at reset values immediately; `start` afterwards is accepted normally.
- DIV=2, `steps`=3, `start` at cycle 0:
  - `lfsr_clk` is high during cycles 1–2, 5–6 and 9–10.
  - `alfsr_rst_n` rises at cycle 13, and COLLECT is entered at cycle 21 (SETTLE=8).
- `steps`=0 → no `lfsr_clk` pulse; SETTLE is entered at cycle 1.
- COLLECT with `rng_in` pattern 1,0,1,1,0,0,1,0 and `data_ready`=1 (macro off) → `data`=0xB2 and `data_valid` pulses for 1 cycle.
- `data_ready`=0 held for 16 bits → first byte retained, `overrun`=1; the next `start` clears `overrun`.
- Macro on, pairs 10,01,00,11,10,10,01,01,10,01 → emitted bits 1,0,1,1,0,0,1,0 → `data`=0xB2.
